id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- Pipeline register between the decode stage (control unit plus register file read) and the execute stage.
- Evaluates the instruction's ARM condition field against the current NZCV status and squashes side-effecting control bits when the condition fails.
- Inserts bubbles on hazard or flush, and holds on freeze.
- Keeps saturating event counters for bubbles and condition-failed instructions.

Parameters:
- DATA_WIDTH, 32, width of PC and register operand values
- COUNT_WIDTH, 16, width of the bubble and condition-fail counters

Ports:
- clk in 1: rising-edge clock
- rst in 1: asynchronous, active-low reset
- flush in 1: branch taken in execute; discard the decode-stage instruction
- freeze in 1: hold all state (memory stall)
- hazard in 1: load-use/RAW hazard; insert a bubble
- cond in 4: instruction condition field
- status_in in 4: current status register {N,Z,C,V}
- execute_command_in in 4, mem_read_in in 1, mem_write_in in 1, wb_enable_in in 1, is_branch_in in 1, status_write_enable_in in 1, is_immediate_in in 1: control unit outputs
- pc_in in DATA_WIDTH, val_rn_in in DATA_WIDTH, val_rm_in in DATA_WIDTH: decode data
- shift_operand_in in 12, signed_imm_24_in in 24: immediate fields
- dest_in in 4, src1_in in 4, src2_in in 4: register addresses
- execute_command_out, mem_read_out, mem_write_out, wb_enable_out, is_branch_out, status_write_enable_out, is_immediate_out, pc_out, val_rn_out, val_rm_out, shift_operand_out, signed_imm_24_out, dest_out, src1_out, src2_out: out, same widths as the inputs; registered copies
- carry_out out 1: C flag sampled when the instruction is loaded (used by ADC/SBC)
- valid_out out 1: 1 = real instruction, 0 = bubble
- bubble_count out COUNT_WIDTH: bubbles inserted
- cond_fail_count out COUNT_WIDTH: instructions squashed by condition

Behaviour:
- Reset (rst=0, asynchronous): every output goes to 0, including counters and valid_out. It overrides any operation in flight.
- One-cycle latency: inputs sampled at edge N appear on the outputs after edge N.
- Per-edge priority: flush > freeze > hazard > normal load.
- flush=1:
  - Load a bubble: all control outputs 0, valid_out=0, execute_command_out=0.
  - Data fields are don't-care; they are loaded as 0.
  - bubble_count increments.
  - Applies even if freeze=1 in the same cycle.
- freeze=1 (no flush): every register, including the counters, holds its value.
- hazard=1 (no flush, no freeze): load a bubble as for flush; bubble_count increments.
- Normal load:
  - All data and control fields are loaded.
  - carry_out = status_in[C].
  - valid_out = 1.
- Condition evaluation (combinational, current cond and status_in):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z
  - GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL 1; cond=4'hF (NV) evaluates false.
- Condition fail on a normal load:
  - wb_enable_out, mem_read_out, mem_write_out, is_branch_out and status_write_enable_out load 0.
  - Remaining fields load normally; valid_out=1.
  - cond_fail_count increments.
- Counters saturate at all-ones and never wrap.
- Bubble, hazard and flush never increment cond_fail_count.
- No combinational path from input to output except through the registers.

Decomposition:
- Shared ISA package/header holds:
  - condition code constants COND_EQ..COND_AL, COND_NV
  - status bit indices N=3, Z=2, C=1, V=0
  - widths: LEN_EXECUTE_COMMAND=4, LEN_REG_ADDR=4, LEN_SHIFT_OPERAND=12, LEN_IMM24=24, LEN_COND=4
  - ENABLE/DISABLE
- One natural sub-module: condition_check (cond, status -> cond_pass), purely combinational. It is reused later by the branch unit.

Test Plan:
1. Reset: assert rst=0 mid-cycle with outputs non-zero -> all outputs 0 immediately, without waiting for clk. Release; first load with cond=AL, wb_enable_in=1, dest_in=5 -> next edge wb_enable_out=1, dest_out=5, valid_out=1.
2. Condition: cond=EQ, status_in=4'b0000, mem_write_in=1, val_rm_in=32'hDEAD -> mem_write_out=0, val_rm_out=32'hDEAD, cond_fail_count=1. Same with status_in=4'b0100 -> mem_write_out=1.
3. Signed conditions: cond=GT, status_in N=1,V=1,Z=0 -> pass; cond=LT, N=1,V=0 -> pass; cond=NV, any status -> fail.
4. Priority: flush=1 and freeze=1 together -> bubble loaded, bubble_count+1. freeze alone for 3 cycles -> outputs and counters unchanged. hazard=1 -> valid_out=0, wb_enable_out=0.
5. Carry capture: status_in C=1 at load, then C=0 while frozen -> carry_out stays 1.
6. Saturation: with COUNT_WIDTH=4, drive 20 consecutive hazard cycles -> bubble_count holds at 4'hF.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared ISA definitions for the decode/execute boundary.
//   - ARM condition codes (COND_EQ .. COND_AL, COND_NV)
//   - status register bit positions {N,Z,C,V}
//   - field widths used by the pipeline registers
//   - packed control-bundle type and its all-zero (bubble) value
package id_ex_stage_reg_pkg;

  localparam int LEN_EXECUTE_COMMAND = 4;
  localparam int LEN_REG_ADDR        = 4;
  localparam int LEN_SHIFT_OPERAND   = 12;
  localparam int LEN_IMM24           = 24;
  localparam int LEN_COND            = 4;

  localparam int STATUS_N = 3;
  localparam int STATUS_Z = 2;
  localparam int STATUS_C = 1;
  localparam int STATUS_V = 0;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [LEN_COND-1:0] COND_EQ = 4'h0;
  localparam logic [LEN_COND-1:0] COND_NE = 4'h1;
  localparam logic [LEN_COND-1:0] COND_CS = 4'h2;
  localparam logic [LEN_COND-1:0] COND_CC = 4'h3;
  localparam logic [LEN_COND-1:0] COND_MI = 4'h4;
  localparam logic [LEN_COND-1:0] COND_PL = 4'h5;
  localparam logic [LEN_COND-1:0] COND_VS = 4'h6;
  localparam logic [LEN_COND-1:0] COND_VC = 4'h7;
  localparam logic [LEN_COND-1:0] COND_HI = 4'h8;
  localparam logic [LEN_COND-1:0] COND_LS = 4'h9;
  localparam logic [LEN_COND-1:0] COND_GE = 4'hA;
  localparam logic [LEN_COND-1:0] COND_LT = 4'hB;
  localparam logic [LEN_COND-1:0] COND_GT = 4'hC;
  localparam logic [LEN_COND-1:0] COND_LE = 4'hD;
  localparam logic [LEN_COND-1:0] COND_AL = 4'hE;
  localparam logic [LEN_COND-1:0] COND_NV = 4'hF;

  typedef struct packed {
    logic [LEN_EXECUTE_COMMAND-1:0] execute_command;
    logic                           mem_read;
    logic                           mem_write;
    logic                           wb_enable;
    logic                           is_branch;
    logic                           status_write_enable;
    logic                           is_immediate;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '{
    execute_command:     4'h0,
    mem_read:            1'b0,
    mem_write:           1'b0,
    wb_enable:           1'b0,
    is_branch:           1'b0,
    status_write_enable: 1'b0,
    is_immediate:        1'b0
  };

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// Decode-to-execute bus.
//   slave  : the ID/EX register (consumes *_in and pipeline controls, drives *_out and counters)
//   master : the surrounding pipeline / bench (drives *_in, observes *_out)
interface id_ex_stage_reg_if
  import id_ex_stage_reg_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
);

  logic flush;
  logic freeze;
  logic hazard;
  logic [LEN_COND-1:0] cond;
  logic [3:0] status_in;

  logic [LEN_EXECUTE_COMMAND-1:0] execute_command_in;
  logic mem_read_in;
  logic mem_write_in;
  logic wb_enable_in;
  logic is_branch_in;
  logic status_write_enable_in;
  logic is_immediate_in;
  logic [DATA_WIDTH-1:0] pc_in;
  logic [DATA_WIDTH-1:0] val_rn_in;
  logic [DATA_WIDTH-1:0] val_rm_in;
  logic [LEN_SHIFT_OPERAND-1:0] shift_operand_in;
  logic [LEN_IMM24-1:0] signed_imm_24_in;
  logic [LEN_REG_ADDR-1:0] dest_in;
  logic [LEN_REG_ADDR-1:0] src1_in;
  logic [LEN_REG_ADDR-1:0] src2_in;

  logic [LEN_EXECUTE_COMMAND-1:0] execute_command_out;
  logic mem_read_out;
  logic mem_write_out;
  logic wb_enable_out;
  logic is_branch_out;
  logic status_write_enable_out;
  logic is_immediate_out;
  logic [DATA_WIDTH-1:0] pc_out;
  logic [DATA_WIDTH-1:0] val_rn_out;
  logic [DATA_WIDTH-1:0] val_rm_out;
  logic [LEN_SHIFT_OPERAND-1:0] shift_operand_out;
  logic [LEN_IMM24-1:0] signed_imm_24_out;
  logic [LEN_REG_ADDR-1:0] dest_out;
  logic [LEN_REG_ADDR-1:0] src1_out;
  logic [LEN_REG_ADDR-1:0] src2_out;
  logic carry_out;
  logic valid_out;
  logic [COUNT_WIDTH-1:0] bubble_count;
  logic [COUNT_WIDTH-1:0] cond_fail_count;

  modport slave (
    input  flush, freeze, hazard, cond, status_in,
    input  execute_command_in, mem_read_in, mem_write_in, wb_enable_in,
    input  is_branch_in, status_write_enable_in, is_immediate_in,
    input  pc_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in,
    input  dest_in, src1_in, src2_in,
    output execute_command_out, mem_read_out, mem_write_out, wb_enable_out,
    output is_branch_out, status_write_enable_out, is_immediate_out,
    output pc_out, val_rn_out, val_rm_out, shift_operand_out, signed_imm_24_out,
    output dest_out, src1_out, src2_out, carry_out, valid_out,
    output bubble_count, cond_fail_count
  );

  modport master (
    output flush, freeze, hazard, cond, status_in,
    output execute_command_in, mem_read_in, mem_write_in, wb_enable_in,
    output is_branch_in, status_write_enable_in, is_immediate_in,
    output pc_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in,
    output dest_in, src1_in, src2_in,
    input  execute_command_out, mem_read_out, mem_write_out, wb_enable_out,
    input  is_branch_out, status_write_enable_out, is_immediate_out,
    input  pc_out, val_rn_out, val_rm_out, shift_operand_out, signed_imm_24_out,
    input  dest_out, src1_out, src2_out, carry_out, valid_out,
    input  bubble_count, cond_fail_count
  );

endinterface

// File: rtl/id_ex_stage_reg_condition_check.sv
// condition_check: purely combinational ARM condition evaluator.
//   cond      in  4 : instruction condition field
//   status    in  4 : {N,Z,C,V}
//   cond_pass out 1 : 1 when the instruction should execute; NV never passes
module condition_check
  import id_ex_stage_reg_pkg::*;
(
  input  logic [LEN_COND-1:0] cond,
  input  logic [3:0]          status,
  output logic                cond_pass
);

  logic n_s;
  logic z_s;
  logic c_s;
  logic v_s;

  assign n_s = status[STATUS_N];
  assign z_s = status[STATUS_Z];
  assign c_s = status[STATUS_C];
  assign v_s = status[STATUS_V];

  // Decode the condition field against the flags.
  always_comb begin
    cond_pass = DISABLE;
    case (cond)
      COND_EQ: cond_pass = z_s;
      COND_NE: cond_pass = ~z_s;
      COND_CS: cond_pass = c_s;
      COND_CC: cond_pass = ~c_s;
      COND_MI: cond_pass = n_s;
      COND_PL: cond_pass = ~n_s;
      COND_VS: cond_pass = v_s;
      COND_VC: cond_pass = ~v_s;
      COND_HI: cond_pass = c_s & ~z_s;
      COND_LS: cond_pass = ~c_s | z_s;
      COND_GE: cond_pass = (n_s == v_s);
      COND_LT: cond_pass = (n_s != v_s);
      COND_GT: cond_pass = ~z_s & (n_s == v_s);
      COND_LE: cond_pass = z_s | (n_s != v_s);
      COND_AL: cond_pass = ENABLE;
      default: cond_pass = DISABLE;
    endcase
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register.
//   clk  in : rising-edge clock
//   rst  in : asynchronous active-low reset, clears every output and counter
//   bus     : id_ex_stage_reg_if.slave -- decode fields in, registered copies out,
//             carry_out (C captured at load), valid_out, bubble/cond-fail counters
// Edge priority: flush > freeze > hazard > normal load. A failing condition squashes
// the side-effecting control bits but still loads a valid instruction.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
)
(
  input  logic            clk,
  input  logic            rst,
  id_ex_stage_reg_if.slave bus
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  // Saturating increment: stays at all-ones instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value);
    if (value == COUNT_MAX) begin
      return value;
    end else begin
      return value + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  logic  cond_pass_s;
  logic  bubble_s;
  ctrl_t ctrl_in_s;
  ctrl_t ctrl_load_s;

  ctrl_t                        ctrl_r;
  logic [DATA_WIDTH-1:0]        pc_r;
  logic [DATA_WIDTH-1:0]        val_rn_r;
  logic [DATA_WIDTH-1:0]        val_rm_r;
  logic [LEN_SHIFT_OPERAND-1:0] shift_operand_r;
  logic [LEN_IMM24-1:0]         signed_imm_24_r;
  logic [LEN_REG_ADDR-1:0]      dest_r;
  logic [LEN_REG_ADDR-1:0]      src1_r;
  logic [LEN_REG_ADDR-1:0]      src2_r;
  logic                         carry_r;
  logic                         valid_r;
  logic [COUNT_WIDTH-1:0]       bubble_count_r;
  logic [COUNT_WIDTH-1:0]       cond_fail_count_r;

  condition_check u_condition_check (
    .cond      (bus.cond),
    .status    (bus.status_in),
    .cond_pass (cond_pass_s)
  );

  // flush wins over freeze; hazard only bubbles when not frozen.
  assign bubble_s = bus.flush | (~bus.freeze & bus.hazard);

  assign ctrl_in_s = '{
    execute_command:     bus.execute_command_in,
    mem_read:            bus.mem_read_in,
    mem_write:           bus.mem_write_in,
    wb_enable:           bus.wb_enable_in,
    is_branch:           bus.is_branch_in,
    status_write_enable: bus.status_write_enable_in,
    is_immediate:        bus.is_immediate_in
  };

  // Squash side-effecting control bits when the condition fails.
  always_comb begin
    ctrl_load_s = ctrl_in_s;
    if (!cond_pass_s) begin
      ctrl_load_s.mem_read            = DISABLE;
      ctrl_load_s.mem_write           = DISABLE;
      ctrl_load_s.wb_enable           = DISABLE;
      ctrl_load_s.is_branch           = DISABLE;
      ctrl_load_s.status_write_enable = DISABLE;
    end else begin
      ctrl_load_s = ctrl_in_s;
    end
  end

  // Pipeline state: reset, bubble insertion, hold, or normal load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_r            <= CTRL_NONE;
      pc_r              <= {DATA_WIDTH{1'b0}};
      val_rn_r          <= {DATA_WIDTH{1'b0}};
      val_rm_r          <= {DATA_WIDTH{1'b0}};
      shift_operand_r   <= {LEN_SHIFT_OPERAND{1'b0}};
      signed_imm_24_r   <= {LEN_IMM24{1'b0}};
      dest_r            <= {LEN_REG_ADDR{1'b0}};
      src1_r            <= {LEN_REG_ADDR{1'b0}};
      src2_r            <= {LEN_REG_ADDR{1'b0}};
      carry_r           <= 1'b0;
      valid_r           <= 1'b0;
      bubble_count_r    <= {COUNT_WIDTH{1'b0}};
      cond_fail_count_r <= {COUNT_WIDTH{1'b0}};
    end else if (bubble_s) begin
      ctrl_r            <= CTRL_NONE;
      pc_r              <= {DATA_WIDTH{1'b0}};
      val_rn_r          <= {DATA_WIDTH{1'b0}};
      val_rm_r          <= {DATA_WIDTH{1'b0}};
      shift_operand_r   <= {LEN_SHIFT_OPERAND{1'b0}};
      signed_imm_24_r   <= {LEN_IMM24{1'b0}};
      dest_r            <= {LEN_REG_ADDR{1'b0}};
      src1_r            <= {LEN_REG_ADDR{1'b0}};
      src2_r            <= {LEN_REG_ADDR{1'b0}};
      carry_r           <= 1'b0;
      valid_r           <= 1'b0;
      bubble_count_r    <= sat_inc(bubble_count_r);
      cond_fail_count_r <= cond_fail_count_r;
    end else if (bus.freeze) begin
      ctrl_r            <= ctrl_r;
      pc_r              <= pc_r;
      val_rn_r          <= val_rn_r;
      val_rm_r          <= val_rm_r;
      shift_operand_r   <= shift_operand_r;
      signed_imm_24_r   <= signed_imm_24_r;
      dest_r            <= dest_r;
      src1_r            <= src1_r;
      src2_r            <= src2_r;
      carry_r           <= carry_r;
      valid_r           <= valid_r;
      bubble_count_r    <= bubble_count_r;
      cond_fail_count_r <= cond_fail_count_r;
    end else begin
      ctrl_r            <= ctrl_load_s;
      pc_r              <= bus.pc_in;
      val_rn_r          <= bus.val_rn_in;
      val_rm_r          <= bus.val_rm_in;
      shift_operand_r   <= bus.shift_operand_in;
      signed_imm_24_r   <= bus.signed_imm_24_in;
      dest_r            <= bus.dest_in;
      src1_r            <= bus.src1_in;
      src2_r            <= bus.src2_in;
      carry_r           <= bus.status_in[STATUS_C];
      valid_r           <= 1'b1;
      bubble_count_r    <= bubble_count_r;
      cond_fail_count_r <= cond_pass_s ? cond_fail_count_r : sat_inc(cond_fail_count_r);
    end
  end

  assign bus.execute_command_out     = ctrl_r.execute_command;
  assign bus.mem_read_out            = ctrl_r.mem_read;
  assign bus.mem_write_out           = ctrl_r.mem_write;
  assign bus.wb_enable_out           = ctrl_r.wb_enable;
  assign bus.is_branch_out           = ctrl_r.is_branch;
  assign bus.status_write_enable_out = ctrl_r.status_write_enable;
  assign bus.is_immediate_out        = ctrl_r.is_immediate;
  assign bus.pc_out                  = pc_r;
  assign bus.val_rn_out              = val_rn_r;
  assign bus.val_rm_out              = val_rm_r;
  assign bus.shift_operand_out       = shift_operand_r;
  assign bus.signed_imm_24_out       = signed_imm_24_r;
  assign bus.dest_out                = dest_r;
  assign bus.src1_out                = src1_r;
  assign bus.src2_out                = src2_r;
  assign bus.carry_out               = carry_r;
  assign bus.valid_out               = valid_r;
  assign bus.bubble_count            = bubble_count_r;
  assign bus.cond_fail_count         = cond_fail_count_r;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for id_ex_stage_reg (COUNT_WIDTH=4 to reach saturation).
module tb_id_ex_stage_reg;
  import id_ex_stage_reg_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  id_ex_stage_reg_if #(.DATA_WIDTH(32), .COUNT_WIDTH(4)) bus ();

  id_ex_stage_reg #(.DATA_WIDTH(32), .COUNT_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.flush = 1'b0; bus.freeze = 1'b0; bus.hazard = 1'b0;
    bus.cond = COND_AL; bus.status_in = 4'h0;
    bus.execute_command_in = 4'h0; bus.mem_read_in = 1'b0; bus.mem_write_in = 1'b0;
    bus.wb_enable_in = 1'b0; bus.is_branch_in = 1'b0; bus.status_write_enable_in = 1'b0;
    bus.is_immediate_in = 1'b0; bus.pc_in = 32'h0; bus.val_rn_in = 32'h0; bus.val_rm_in = 32'h0;
    bus.shift_operand_in = 12'h0; bus.signed_imm_24_in = 24'h0;
    bus.dest_in = 4'h0; bus.src1_in = 4'h0; bus.src2_in = 4'h0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".exec"},   64'(bus.execute_command_out), 64'h0);
    chk({tag, ".ctrl"},   64'({bus.mem_read_out, bus.mem_write_out, bus.wb_enable_out,
                               bus.is_branch_out, bus.status_write_enable_out, bus.is_immediate_out}), 64'h0);
    chk({tag, ".pc"},     64'(bus.pc_out), 64'h0);
    chk({tag, ".rn_rm"},  64'({bus.val_rn_out, bus.val_rm_out}), 64'h0);
    chk({tag, ".imm"},    64'({bus.shift_operand_out, bus.signed_imm_24_out}), 64'h0);
    chk({tag, ".regs"},   64'({bus.dest_out, bus.src1_out, bus.src2_out}), 64'h0);
    chk({tag, ".carry"},  64'(bus.carry_out), 64'h0);
    chk({tag, ".valid"},  64'(bus.valid_out), 64'h0);
    chk({tag, ".bubble"}, 64'(bus.bubble_count), 64'h0);
    chk({tag, ".cfail"},  64'(bus.cond_fail_count), 64'h0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    clear_inputs();
    #12;
    check_all_zero("reset");

    // First load after reset release.
    rst = 1'b1;
    bus.cond = COND_AL; bus.wb_enable_in = 1'b1; bus.dest_in = 4'h5; bus.status_in = 4'b0010;
    step();
    chk("load1.wb",    64'(bus.wb_enable_out), 64'h1);
    chk("load1.dest",  64'(bus.dest_out), 64'h5);
    chk("load1.valid", 64'(bus.valid_out), 64'h1);
    chk("load1.carry", 64'(bus.carry_out), 64'h1);

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    #2 rst = 1'b0;
    #1 check_all_zero("async_rst");
    rst = 1'b1;
    step();
    chk("load2.wb",    64'(bus.wb_enable_out), 64'h1);
    chk("load2.dest",  64'(bus.dest_out), 64'h5);
    chk("load2.valid", 64'(bus.valid_out), 64'h1);
    chk("load2.cfail", 64'(bus.cond_fail_count), 64'h0);

    // EQ with Z=0 fails: store squashed, data kept.
    clear_inputs();
    bus.cond = COND_EQ; bus.status_in = 4'b0000; bus.mem_write_in = 1'b1; bus.val_rm_in = 32'hDEAD;
    step();
    chk("eq_fail.mw",    64'(bus.mem_write_out), 64'h0);
    chk("eq_fail.rm",    64'(bus.val_rm_out), 64'hDEAD);
    chk("eq_fail.valid", 64'(bus.valid_out), 64'h1);
    chk("eq_fail.cfail", 64'(bus.cond_fail_count), 64'h1);
    bus.status_in = 4'b0100;
    step();
    chk("eq_pass.mw",    64'(bus.mem_write_out), 64'h1);
    chk("eq_pass.cfail", 64'(bus.cond_fail_count), 64'h1);

    // Signed and unsigned compare conditions.
    clear_inputs();
    bus.wb_enable_in = 1'b1;
    bus.cond = COND_GT; bus.status_in = 4'b1001;
    step();
    chk("gt_pass.wb", 64'(bus.wb_enable_out), 64'h1);
    bus.cond = COND_LT; bus.status_in = 4'b1000;
    step();
    chk("lt_pass.wb", 64'(bus.wb_enable_out), 64'h1);
    chk("lt_pass.cfail", 64'(bus.cond_fail_count), 64'h1);
    bus.cond = COND_NV; bus.status_in = 4'b0100;
    step();
    chk("nv_fail.wb",    64'(bus.wb_enable_out), 64'h0);
    chk("nv_fail.cfail", 64'(bus.cond_fail_count), 64'h2);
    bus.cond = COND_HI; bus.status_in = 4'b0110;
    step();
    chk("hi_fail.wb",    64'(bus.wb_enable_out), 64'h0);
    chk("hi_fail.cfail", 64'(bus.cond_fail_count), 64'h3);
    bus.cond = COND_LS;
    step();
    chk("ls_pass.wb",    64'(bus.wb_enable_out), 64'h1);
    chk("ls_pass.cfail", 64'(bus.cond_fail_count), 64'h3);

    // flush beats freeze: a bubble is still inserted.
    bus.cond = COND_AL; bus.dest_in = 4'h9; bus.flush = 1'b1; bus.freeze = 1'b1;
    step();
    chk("flush.valid",  64'(bus.valid_out), 64'h0);
    chk("flush.wb",     64'(bus.wb_enable_out), 64'h0);
    chk("flush.dest",   64'(bus.dest_out), 64'h0);
    chk("flush.bubble", 64'(bus.bubble_count), 64'h1);
    chk("flush.cfail",  64'(bus.cond_fail_count), 64'h3);

    // Full-field normal load with C=1.
    clear_inputs();
    bus.cond = COND_AL; bus.status_in = 4'b0010; bus.execute_command_in = 4'h9;
    bus.mem_read_in = 1'b1; bus.wb_enable_in = 1'b1; bus.is_branch_in = 1'b1;
    bus.status_write_enable_in = 1'b1; bus.is_immediate_in = 1'b1;
    bus.pc_in = 32'h100; bus.val_rn_in = 32'h12345678; bus.val_rm_in = 32'hCAFEF00D;
    bus.shift_operand_in = 12'hABC; bus.signed_imm_24_in = 24'h123456;
    bus.dest_in = 4'h7; bus.src1_in = 4'h3; bus.src2_in = 4'hC;
    step();
    chk("full.exec",  64'(bus.execute_command_out), 64'h9);
    chk("full.ctrl",  64'({bus.mem_read_out, bus.mem_write_out, bus.wb_enable_out,
                           bus.is_branch_out, bus.status_write_enable_out, bus.is_immediate_out}), 64'h2F);
    chk("full.pc",    64'(bus.pc_out), 64'h100);
    chk("full.rn_rm", 64'({bus.val_rn_out, bus.val_rm_out}), 64'h12345678CAFEF00D);
    chk("full.imm",   64'({bus.shift_operand_out, bus.signed_imm_24_out}), 64'hABC123456);
    chk("full.regs",  64'({bus.dest_out, bus.src1_out, bus.src2_out}), 64'h73C);
    chk("full.carry", 64'(bus.carry_out), 64'h1);
    chk("full.valid", 64'(bus.valid_out), 64'h1);

    // Freeze holds everything, even with hazard and a failing condition present.
    bus.freeze = 1'b1; bus.hazard = 1'b1; bus.cond = COND_NV; bus.status_in = 4'b0000;
    bus.dest_in = 4'h2; bus.pc_in = 32'h200;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("freeze.dest",   64'(bus.dest_out), 64'h7);
      chk("freeze.pc",     64'(bus.pc_out), 64'h100);
      chk("freeze.carry",  64'(bus.carry_out), 64'h1);
      chk("freeze.valid",  64'(bus.valid_out), 64'h1);
      chk("freeze.bubble", 64'(bus.bubble_count), 64'h1);
      chk("freeze.cfail",  64'(bus.cond_fail_count), 64'h3);
    end

    // Hazard bubble; failing condition must not count.
    bus.freeze = 1'b0;
    step();
    chk("hazard.valid",  64'(bus.valid_out), 64'h0);
    chk("hazard.wb",     64'(bus.wb_enable_out), 64'h0);
    chk("hazard.bubble", 64'(bus.bubble_count), 64'h2);
    chk("hazard.cfail",  64'(bus.cond_fail_count), 64'h3);

    // 20 more hazard cycles: bubble counter saturates at 4'hF.
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("bubble_sat", 64'(bus.bubble_count), (2 + k > 15) ? 64'hF : 64'(2 + k));
    end
    chk("bubble_sat.valid", 64'(bus.valid_out), 64'h0);

    // 15 condition-failed loads: cond_fail counter saturates too.
    bus.hazard = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
    end
    chk("cfail_sat",        64'(bus.cond_fail_count), 64'hF);
    chk("cfail_sat.bubble", 64'(bus.bubble_count), 64'hF);
    chk("cfail_sat.valid",  64'(bus.valid_out), 64'h1);
    chk("cfail_sat.wb",     64'(bus.wb_enable_out), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
